// File: rtl/pixel_plot_sink.sv
// -----------------------------------------------------------------------------
// pixel_plot_sink
//
// Receiving end of the pixel-plot interface. Plot requests (x, y, colour)
// arrive one per cycle on iPlot. Off-screen requests are discarded and counted.
// On-screen requests are buffered in a small FIFO. They are then converted to
// a linear frame-buffer address and issued as single-beat writes under a grant
// handshake. One output register sits behind the FIFO, so the sink holds
// FIFO_DEPTH + 1 pixels in total while memory is busy.
//
// Ports
//   iClock      in   system clock, rising edge
//   iResetn     in   asynchronous active-low reset
//   iX, iY      in   pixel coordinate (9 / 8 bits)
//   iColour     in   pixel colour, 3-bit RGB
//   iPlot       in   plot request strobe, one pixel per cycle when high
//   oReady      out  FIFO can accept a request (registered count not full)
//   oMemAddr    out  frame-buffer write address, y*X_SCREEN_PIXELS + x
//   oMemData    out  frame-buffer write colour
//   oMemWe      out  write request valid
//   iMemGrant   in   memory accepts the pending write this cycle
//   oEmpty      out  FIFO empty and no write pending
//   oOverflow   out  sticky: an on-screen request was dropped (FIFO full)
//   oDropCount  out  saturating count of requests dropped on a full FIFO
//   oClipCount  out  saturating count of off-screen requests discarded
// -----------------------------------------------------------------------------
module pixel_plot_sink #(
  parameter int X_SCREEN_PIXELS = 320,
  parameter int Y_SCREEN_PIXELS = 240,
  parameter int FIFO_DEPTH      = 8,   // power of 2, at least 2
  parameter int ADDR_WIDTH      = 17
) (
  input  logic                  iClock,
  input  logic                  iResetn,
  input  logic [8:0]            iX,
  input  logic [7:0]            iY,
  input  logic [2:0]            iColour,
  input  logic                  iPlot,
  output logic                  oReady,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [2:0]            oMemData,
  output logic                  oMemWe,
  input  logic                  iMemGrant,
  output logic                  oEmpty,
  output logic                  oOverflow,
  output logic [7:0]            oDropCount,
  output logic [7:0]            oClipCount
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [31:0]      X_LIMIT    = 32'(X_SCREEN_PIXELS);
  localparam logic [31:0]      Y_LIMIT    = 32'(Y_SCREEN_PIXELS);

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Storage and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // ---------------------------------------------------------------------------
  // Per-cycle decisions
  // ---------------------------------------------------------------------------
  logic                  off_screen;
  logic                  fifo_full;
  logic                  fifo_nonempty;
  logic                  write_done;
  logic                  push;
  logic                  pop;
  entry_t                head;
  logic [ADDR_WIDTH-1:0] x_ext;
  logic [ADDR_WIDTH-1:0] y_ext;
  logic [ADDR_WIDTH-1:0] head_addr;

  // NOTE: combinational logic gets a default for every output first, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    off_screen    = 1'b0;
    fifo_full     = 1'b0;
    fifo_nonempty = 1'b0;
    write_done    = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;

    off_screen    = (32'(iX) >= X_LIMIT) || (32'(iY) >= Y_LIMIT);

    // Fullness comes only from the registered count. A pop in this cycle
    // does not make room for a push in the same cycle.
    fifo_full     = (count == FULL_COUNT);
    fifo_nonempty = (count != '0);

    write_done    = oMemWe && iMemGrant;
    push          = iPlot && !off_screen && !fifo_full;

    // Refill the output register when it is idle, or when its write retires
    // on this edge. This keeps one pixel per cycle with grant held high.
    pop           = fifo_nonempty && (!oMemWe || write_done);
  end

  // Address conversion for the entry at the head of the FIFO. The default
  // 320-pixel width uses y*256 + y*64 so no multiplier is needed. Other widths
  // fall back to a plain multiply.
  always_comb begin
    head  = mem[rd_ptr];
    x_ext = ADDR_WIDTH'(head.x);
    y_ext = ADDR_WIDTH'(head.y);
    if (X_SCREEN_PIXELS == 320) begin
      head_addr = (y_ext << 8) + (y_ext << 6) + x_ext;
    end else begin
      head_addr = (y_ext * ADDR_WIDTH'(X_SCREEN_PIXELS)) + x_ext;
    end
  end

  // NOTE: the FIFO data array has no reset. The valid pointers and count
  // qualify every entry, and leaving it out of reset lets it map to RAM.
  always_ff @(posedge iClock) begin
    if (push) begin
      mem[wr_ptr] <= '{x: iX, y: iY, colour: iColour};
    end
  end

  // NOTE: all registered state uses non-blocking assignments. Every flop then
  // samples the pre-edge value of every other flop.
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: the single write currently offered to memory. The
  // address, data and valid bit hold while grant is low.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oMemWe   <= 1'b0;
      oMemAddr <= '0;
      oMemData <= '0;
    end else if (pop) begin
      oMemWe   <= 1'b1;
      oMemAddr <= head_addr;
      oMemData <= head.colour;
    end else if (write_done) begin
      oMemWe   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Discard statistics. Clipping takes priority, so an off-screen request
  // counts as a clip even when the FIFO is full.
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      oOverflow  <= 1'b0;
      oDropCount <= '0;
      oClipCount <= '0;
    end else if (iPlot) begin
      if (off_screen) begin
        if (oClipCount != 8'hFF) begin
          oClipCount <= oClipCount + 8'd1;
        end
      end else if (fifo_full) begin
        oOverflow <= 1'b1;
        if (oDropCount != 8'hFF) begin
          oDropCount <= oDropCount + 8'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags, decoded from registered state only
  // ---------------------------------------------------------------------------
  assign oReady = !fifo_full;
  assign oEmpty = !fifo_nonempty && !oMemWe;

endmodule

// File: doc/pixel_plot_sink.md
Name: pixel_plot_sink

Overview:
Receiving end of the pixel-plot interface (X, Y, colour, plot strobe) driven by the note/key drawing datapaths. It buffers plot requests in a small FIFO, clips off-screen coordinates and converts (x,y) to a linear frame-buffer address. It issues single-beat writes to the frame-buffer RAM port under a grant handshake. It sits between the drawing datapaths and the frame-buffer memory, and absorbs bursts such as a 16-pixel 4x4 key highlight while memory is busy.

Parameters:
X_SCREEN_PIXELS, 320, visible width; x >= this is clipped
Y_SCREEN_PIXELS, 240, visible height; y >= this is clipped
FIFO_DEPTH, 8, request FIFO entries (power of 2)
ADDR_WIDTH, 17, frame-buffer address width (76800 locations)

Ports:
iClock  in  1  system clock, rising edge
iResetn  in  1  asynchronous active-low reset
iX  in  9  pixel x coordinate
iY  in  8  pixel y coordinate
iColour  in  3  pixel colour (RGB, 0-7)
iPlot  in  1  plot request strobe, one pixel per cycle high
oReady  out  1  high = FIFO can accept (not full)
oMemAddr  out  ADDR_WIDTH  frame-buffer write address
oMemData  out  3  frame-buffer write colour
oMemWe  out  1  write request valid
iMemGrant  in  1  memory accepts the write this cycle
oEmpty  out  1  FIFO empty and no write pending
oOverflow  out  1  sticky: a request was dropped because FIFO was full
oDropCount  out  8  saturating count of requests dropped because FIFO was full
oClipCount  out  8  saturating count of off-screen requests discarded

Behaviour:
- Reset (async, any time incl. mid-burst): FIFO pointers/count=0, oMemWe=0, oMemAddr=0, oMemData=0, oOverflow=0, oDropCount=0, oClipCount=0, oEmpty=1, oReady=1. oMemWe drops immediately, not at next edge. In-flight requests are lost.
- Input check, at each edge with iPlot=1:
  - iX>=X_SCREEN_PIXELS or iY>=Y_SCREEN_PIXELS: discard, oClipCount+1 (saturate at 255). Counts as clip even if FIFO full; no drop count.
  - Else if FIFO full (registered count==FIFO_DEPTH): discard, oDropCount+1 (saturate at 255), oOverflow<=1.
  - Else push {iX,iY,iColour}.
- oReady = (count != FIFO_DEPTH), from registered state. A pop in the same cycle does not free space for a push in that cycle.
- Output register (one entry) holds the current write:
  - A write completes on an edge with oMemWe=1 and iMemGrant=1.
  - Pop from the FIFO when the register is empty, or when it completes this cycle; the FIFO must be non-empty.
  - The popped entry loads oMemAddr = y*320 + x, computed as (y<<8)+(y<<6)+x at ADDR_WIDTH bits, plus oMemData=colour. Set oMemWe=1.
  - If nothing is popped and the write completes, oMemWe<=0.
  - While iMemGrant=0, oMemAddr/oMemData/oMemWe hold stable.
- Latency: push at edge N into an empty sink gives oMemWe=1 after edge N+1. With grant held high, sustained throughput is one pixel per cycle.
- Capacity: FIFO_DEPTH entries + 1 output register (9 by default).
- Ordering: writes leave strictly in accepted order.
- Simultaneous push and pop with count between 0 and FIFO_DEPTH: count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- oEmpty = (count==0) && !oMemWe.
- oOverflow clears only on reset.

Test Plan:
- Single pixel: iPlot=1 for one cycle with (66,124,3'b110), grant=1 -> after 2 edges oMemWe=1 for exactly 1 cycle, oMemAddr=39746, oMemData=6, then oEmpty=1.
- Corner and clipping: (319,239,1) -> addr 76799 written. (320,10,1) and (5,240,1) -> no write, oClipCount=2, oDropCount=0.
- Backpressure burst: grant=0, 16 consecutive pixels x=66..69, y=124..127 -> first 9 retained, oReady=0 after the 9th accept, oDropCount=7, oOverflow=1. Raise grant -> 9 writes in input order (addr 39746, 39747, 39748, 39749, 40066, ...), one per cycle.
- Streaming: grant=1, 16 back-to-back pixels -> 16 writes on 16 consecutive cycles starting 2 edges after the first, no drops, oReady stays 1.
- Grant toggling: grant alternating 1/0 during a 5-pixel stream -> each address held stable while grant=0, every pixel written exactly once.
- Reset mid-burst: assert iResetn=0 mid-cycle with 5 entries pending -> oMemWe=0 immediately, all counters 0, oEmpty=1. After release, a new pixel (0,0,7) writes addr 0 at the normal latency.
